pc_sequencer: RTL and testbench

//  Fetch/execute sequencer for the Hack program counter. Fetches each instruction over a
//  req/ack handshake, resolves the jump condition from ALU flags, and issues exactly one
//  pc_load or pc_inc pulse per instruction. Sits between instruction ROM, ALU flags and PC.

---
 rtl/pc_sequencer_pkg.sv | 26 ++
 rtl/pc_sequencer_if.sv | 41 ++++
 rtl/pc_sequencer_jump_cond.sv | 34 +++
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : pc_sequencer_pkg                                                |
// | Brief  : Shared types and constants for the Hack PC fetch/execute        |
// |          sequencer: state encoding, default width, C-instruction flag    |
// |          bit, jump-field slice and the unconditional-jump code.          |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package pc_sequencer_pkg;

  localparam int         c_width_def  = 16;
  localparam int         c_cinstr_bit = 15;   // 1 = C-instruction, 0 = A-instruction
  localparam int         c_jf_msb     = 2;    // jump field is instr[2:0]
  localparam int         c_jf_lsb     = 0;
  localparam logic [2:0] c_jmp        = 3'b111;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : pc_sequencer_if                                                 |
// | Brief  : Bundle of ROM fetch handshake, ALU flags and PC control lines   |
// |          around the sequencer. master = sequencer, slave = environment.  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH = c_width_def
);

  logic [WIDTH-1:0] pc;
  logic             instr_req;
  logic             instr_ack;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] a_reg;
  logic             zr;
  logic             ng;
  logic             stall;
  logic [WIDTH-1:0] ir;
  logic             ir_valid;
  logic             pc_reset;
  logic             pc_load;
  logic             pc_inc;
  logic [WIDTH-1:0] pc_in;
  logic             halted;

  modport master (
    input  pc, instr_ack, instr, a_reg, zr, ng, stall,
    output instr_req, ir, ir_valid, pc_reset, pc_load, pc_inc, pc_in, halted
  );

  modport slave (
    output pc, instr_ack, instr, a_reg, zr, ng, stall,
    input  instr_req, ir, ir_valid, pc_reset, pc_load, pc_inc, pc_in, halted
  );

endinterface
`default_nettype wire

// File: rtl/pc_sequencer_jump_cond.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : pc_sequencer_jump_cond                                          |
// | Brief  : Combinational Hack jump decode from the instruction type bit,   |
// |          the 3-bit jump field and the ALU zr/ng flags.                   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module pc_sequencer_jump_cond
  import pc_sequencer_pkg::*;
(
  input  logic       i_cinstr,
  input  logic [2:0] i_jfield,
  input  logic       i_zr,
  input  logic       i_ng,
  output logic       o_jump
);

  // A-instructions never jump; C-instructions test lt/eq/gt against the flags.
  // zr=ng=1 is not special-cased: it simply decodes through the same terms.
  always_comb begin
    o_jump = 1'b0;
    if (i_cinstr) begin
      if (i_jfield == c_jmp) begin
        o_jump = 1'b1;
      end else begin
        o_jump = (i_jfield[2] & i_ng) |
                 (i_jfield[1] & i_zr) |
                 (i_jfield[0] & ~i_ng & ~i_zr);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : pc_sequencer                                                    |
// | Brief  : Hack program-counter fetch/execute sequencer. Fetches over a    |
// |          req/ack handshake, resolves the jump from ALU flags and issues  |
// |          exactly one pc_load or pc_inc pulse per instruction.            |
// | Config : HALT_DETECT_EN - when defined, a taken jump to the current PC   |
// |          parks the sequencer in HALT (halted=1) until reset.             |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH        = c_width_def,
  parameter int RESET_CYCLES = 1
)(
  input  logic                 clk,
  input  logic                 reset,      // asynchronous, active low
  pc_sequencer_if.master       bus
);

  localparam int                 c_cnt_w    = $clog2(RESET_CYCLES + 1) + 1;
  localparam logic [c_cnt_w-1:0] c_rst_last = c_cnt_w'(RESET_CYCLES);

  state_t             r_state;
  state_t             w_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_ir;
  logic               r_jump;
  logic               w_jump;

  pc_sequencer_jump_cond u_jump_cond (
    .i_cinstr (r_ir[c_cinstr_bit]),
    .i_jfield (r_ir[c_jf_msb:c_jf_lsb]),
    .i_zr     (bus.zr),
    .i_ng     (bus.ng),
    .o_jump   (w_jump)
  );

  // State register; reset forces RST immediately so fetch requests drop at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RST;
    else        r_state <= w_next;
  end

  // Post-reset hold counter: pc_reset is driven while the count is 1..RESET_CYCLES.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == ST_RST && r_cnt != c_rst_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Instruction capture on the accepted fetch, jump decision frozen leaving EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir   <= '0;
      r_jump <= 1'b0;
    end else begin
      if (r_state == ST_FETCH && bus.instr_ack) r_ir <= bus.instr;
      if (r_state == ST_EXEC && !bus.stall)     r_jump <= w_jump;
    end
  end

  // Next-state and Moore outputs; PC controls are mutually exclusive by state.
  always_comb begin
    w_next        = r_state;
    bus.instr_req = 1'b0;
    bus.ir_valid  = 1'b0;
    bus.pc_reset  = 1'b0;
    bus.pc_load   = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.halted    = 1'b0;
    case (r_state)
      ST_RST: begin
        bus.pc_reset = (r_cnt != '0);
        if (r_cnt == c_rst_last) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        bus.instr_req = 1'b1;
        if (bus.instr_ack) w_next = ST_EXEC;
      end
      ST_EXEC: begin
        bus.ir_valid = 1'b1;
        if (!bus.stall) w_next = ST_UPDATE;
      end
      ST_UPDATE: begin
`ifdef HALT_DETECT_EN
        if (r_jump && (bus.a_reg == bus.pc)) begin
          w_next = ST_HALT;
        end else begin
          bus.pc_load = r_jump;
          bus.pc_inc  = ~r_jump;
          w_next      = ST_FETCH;
        end
`else
        bus.pc_load = r_jump;
        bus.pc_inc  = ~r_jump;
        w_next      = ST_FETCH;
`endif
      end
`ifdef HALT_DETECT_EN
      ST_HALT: begin
        bus.halted = 1'b1;
      end
`endif
      default: begin
        w_next = ST_RST;
      end
    endcase
  end

  assign bus.ir    = r_ir;
  assign bus.pc_in = bus.a_reg;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_pc_sequencer                                                 |
// | Brief  : Self-checking bench for pc_sequencer: table of instructions     |
// |          with a pulse scoreboard, plus reset / self-jump sequences.      |
// |          Build with +define+HALT_DETECT_EN to exercise HALT.             |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_pc_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(16)) bus ();

  pc_sequencer #(.WIDTH(16), .RESET_CYCLES(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // kind: 0 = expect pc_inc, 1 = expect pc_load, 2 = expect halt (no pulse)
  typedef struct {
    logic [15:0] instr;
    logic [15:0] a_reg;
    logic        zr;
    logic        ng;
    int          waits;
    int          stalls;
    int          kind;
  } vec_t;

  typedef struct {
    logic        load;
    logic [15:0] target;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // PC neighbour model: reacts to the sequencer's control pulses.
  always @(posedge clk or negedge reset) begin
    if (!reset)            bus.pc <= 16'd0;
    else if (bus.pc_reset) bus.pc <= 16'd0;
    else if (bus.pc_load)  bus.pc <= bus.pc_in;
    else if (bus.pc_inc)   bus.pc <= bus.pc + 16'd1;
  end

  // Scoreboard consumer: every load/inc pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset && (bus.pc_load || bus.pc_inc)) begin
      check("pulse_onehot", 32'(bus.pc_load) + 32'(bus.pc_inc) + 32'(bus.pc_reset), 32'd1);
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pulse: got load=%0b inc=%0b, expected no pulse",
                 bus.pc_load, bus.pc_inc);
      end else begin
        e = sb_q.pop_front();
        check("pulse_load", 32'(bus.pc_load), 32'(e.load));
        if (e.load) check("pulse_target", 32'(bus.pc_in), 32'(e.target));
      end
    end
  end

  // Act as ROM + flag source for one instruction; called at a negedge in FETCH.
  task automatic do_instr(input vec_t v, input string tag);
    int guard = 0;
    while (bus.instr_req !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_req"}, 32'(bus.instr_req), 32'd1);
    if (v.kind != 2) sb_q.push_back('{load: (v.kind == 1), target: v.a_reg});
    bus.instr     = v.instr;
    bus.a_reg     = v.a_reg;
    bus.zr        = v.zr;
    bus.ng        = v.ng;
    bus.stall     = (v.stalls != 0);
    bus.instr_ack = 1'b0;
    repeat (v.waits) @(negedge clk);
    check({tag, "_req_held"}, 32'(bus.instr_req), 32'd1);
    bus.instr_ack = 1'b1;
    @(negedge clk);
    // EXEC: ack stays high with a different word to show it is ignored here.
    bus.instr = ~v.instr;
    if (v.stalls == 0) bus.instr_ack = 1'b0;
    check({tag, "_ir"}, 32'(bus.ir), 32'(v.instr));
    check({tag, "_exec"}, {30'd0, bus.ir_valid, bus.instr_req}, 32'b10);
    for (int s = 0; s < v.stalls; s++) begin
      @(negedge clk);
      check({tag, "_stall_hold"}, {14'd0, bus.ir_valid, bus.ir, bus.pc_load},
            {14'd0, 1'b1, v.instr, 1'b0});
      check({tag, "_stall_noinc"}, 32'(bus.pc_inc), 32'd0);
    end
    bus.stall     = 1'b0;
    bus.instr_ack = 1'b0;
    @(negedge clk);
    check({tag, "_update"}, {30'd0, bus.ir_valid, bus.instr_req}, 32'b00);
    @(negedge clk);
    check({tag, "_next_req"}, 32'(bus.instr_req), (v.kind != 2) ? 32'd1 : 32'd0);
    if (v.kind == 2) check({tag, "_halted"}, 32'(bus.halted), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    bus.instr_ack = 1'b0;
    bus.instr     = 16'd0;
    bus.a_reg     = 16'd0;
    bus.zr        = 1'b0;
    bus.ng        = 1'b0;
    bus.stall     = 1'b0;

    //            instr     a_reg     zr    ng    w  s  kind
    vecs[0]  = '{16'h0005, 16'd0,    1'b0, 1'b0, 2, 0, 0};  // A-instr, 2 ROM waits
    vecs[1]  = '{16'hE302, 16'd100,  1'b1, 1'b0, 0, 0, 1};  // JEQ taken
    vecs[2]  = '{16'hE302, 16'd100,  1'b0, 1'b0, 0, 0, 0};  // JEQ not taken
    vecs[3]  = '{16'hE304, 16'd200,  1'b0, 1'b1, 1, 0, 1};  // JLT taken
    vecs[4]  = '{16'hE301, 16'd300,  1'b0, 1'b0, 0, 0, 1};  // JGT taken
    vecs[5]  = '{16'hE301, 16'd300,  1'b1, 1'b0, 0, 0, 0};  // JGT not taken
    vecs[6]  = '{16'hE304, 16'd5,    1'b1, 1'b0, 0, 0, 0};  // JLT not taken
    vecs[7]  = '{16'hEA87, 16'hFFFF, 1'b1, 1'b1, 0, 0, 1};  // JMP to top of memory
    vecs[8]  = '{16'h0005, 16'd0,    1'b0, 1'b0, 0, 0, 0};  // inc wraps PC to 0
    vecs[9]  = '{16'hE300, 16'h0077, 1'b1, 1'b1, 0, 0, 0};  // null jump field
    vecs[10] = '{16'hE302, 16'h1234, 1'b1, 1'b0, 0, 4, 1};  // 4 stall cycles
    vecs[11] = '{16'h8002, 16'h0042, 1'b1, 1'b0, 3, 0, 1};  // minimal C-instr JEQ
    vecs[12] = '{16'h7FFF, 16'h0099, 1'b1, 1'b1, 0, 0, 0};  // A-instr, jump bits set
    vecs[13] = '{16'hE301, 16'h0050, 1'b1, 1'b1, 0, 0, 0};  // illegal flags, JGT

    // Reset asserted: everything quiet.
    @(negedge clk);
    check("rst_outputs", {26'd0, bus.instr_req, bus.ir_valid, bus.pc_reset,
                          bus.pc_load, bus.pc_inc, bus.halted}, 32'd0);
    check("rst_ir", 32'(bus.ir), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_pc_reset", {30'd0, bus.pc_reset, bus.instr_req}, 32'b10);
    @(negedge clk);
    check("rst_to_fetch", {30'd0, bus.pc_reset, bus.instr_req}, 32'b01);

    for (int i = 0; i < 14; i++) begin
      do_instr(vecs[i], $sformatf("v%0d", i));
      if (i == 8) check("pc_wrap", 32'(bus.pc), 32'd0);
    end

    // Reset in the middle of a fetch: request and ir clear without a clock.
    check("midrst_pre_req", 32'(bus.instr_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_req", 32'(bus.instr_req), 32'd0);
    check("midrst_ir", 32'(bus.ir), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_pc_reset", 32'(bus.pc_reset), 32'd1);
    @(negedge clk);
    check("midrst_refetch", 32'(bus.instr_req), 32'd1);

    // Self-jump: move PC to 7, then JMP to 7.
    do_instr('{16'hEA87, 16'd7, 1'b0, 1'b0, 0, 0, 1}, "sj_setup");
    check("sj_pc", 32'(bus.pc), 32'd7);
`ifdef HALT_DETECT_EN
    do_instr('{16'hEA87, 16'd7, 1'b0, 1'b0, 0, 0, 2}, "sj_halt");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("halt_hold", {30'd0, bus.halted, bus.instr_req}, 32'b10);
    end
    reset = 1'b0;
    #1;
    check("halt_exit", {30'd0, bus.halted, bus.instr_req}, 32'b00);
    @(negedge clk);
    reset = 1'b1;
`else
    do_instr('{16'hEA87, 16'd7, 1'b0, 1'b0, 0, 0, 1}, "sj_loop0");
    do_instr('{16'hEA87, 16'd7, 1'b0, 1'b0, 1, 0, 1}, "sj_loop1");
    check("sj_halted_tied", 32'(bus.halted), 32'd0);
    check("sj_pc_loop", 32'(bus.pc), 32'd7);
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
